rf_multiport: RTL

Parametrised general-purpose register file for the lab CPU datapath. It is the successor of the fixed 32x32, two-read/one-write RF. It adds configurable width, depth and read-port count, per-byte write enables, an optional hardwired zero register, and optional write-to-read bypass. It sits between the decode stage (read addresses) and the writeback stage (write port).

---
 rtl/rf_pkg.sv | 23 ++
 rtl/rf_multiport_read_port.sv | 34 +++
 rtl/rf_multiport.sv | 75 +++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and the byte-merge helper for the multiport register file.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_NUM_RD = 2;
    localparam int RF_MAX_W  = 1024;
    localparam int RF_MAX_BE = RF_MAX_W / 8;

    // Callers zero-extend their operands and truncate the result to DATA_W.
    function automatic logic [RF_MAX_W-1:0] be_merge(
        input logic [RF_MAX_W-1:0]  old_w,
        input logic [RF_MAX_W-1:0]  new_w,
        input logic [RF_MAX_BE-1:0] be
    );
        logic [RF_MAX_W-1:0] res;
        for (int k = 0; k < RF_MAX_BE; k++) begin
            res[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rf_multiport_read_port.sv
// One combinational read port: range check, zero-register force, bypass.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_merged,
    input  logic [DATA_W-1:0] regs [DEPTH],
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic in_range;
    logic is_zero;
    logic hit;

    always_comb begin
        in_range = 32'(rd_addr) < DEPTH;
        is_zero  = (ZERO_REG != 0) && (rd_addr == '0);
        hit      = (BYPASS != 0) && wr_en && !rst && (wr_addr == rd_addr);
        rd_data  = '0;
        if (in_range && !is_zero) begin
            rd_data = hit ? wr_merged : regs[rd_addr];
        end
    end

endmodule

// File: rtl/rf_multiport.sv
// Parametrised register file: storage and write path; read ports are
// replicated instances of rf_read_port sharing the merged write word.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [DATA_W-1:0]        wr_data
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              wr_in_range;
    logic              wr_ok;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_merged;

    always_comb begin
        wr_in_range = 32'(wr_addr) < DEPTH;
        wr_ok       = wr_in_range &&
                      !((ZERO_REG != 0) && (wr_addr == '0));
        wr_old      = '0;
        if (wr_in_range) begin
            wr_old = regs_q[wr_addr];
        end
        wr_merged = DATA_W'(be_merge(RF_MAX_W'(wr_old),
                                     RF_MAX_W'(wr_data),
                                     RF_MAX_BE'(wr_be)));
        regs_d = regs_q;
        if (wr_en && wr_ok) begin
            regs_d[wr_addr] = wr_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .rst       (rst),
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_merged (wr_merged),
            .regs      (regs_q),
            .rd_addr   (rd_addr[i*ADDR_W +: ADDR_W]),
            .rd_data   (rd_data[i*DATA_W +: DATA_W])
        );
    end

endmodule
